wb_write_queue: RTL and testbench

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

---
 rtl/wb_write_queue_if.sv | 42 ++++
 rtl/wb_write_queue.sv | 105 ++++++++++
 tb/tb_wb_write_queue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/wb_write_queue_if.sv
// Writeback-queue bus: two result sources in, one register-file write port and two bypass lookups out.
// valid/ready: a source result is taken at the rising edge only when in_ready was high before that edge;
// in_ready does not depend on the valids, and a valid raised while in_ready is low is dropped, not held.
interface wb_write_queue_if #(
  parameter int WIDTH  = 16,
  parameter int N_REGS = 8,
  parameter int DEPTH  = 4
);
  localparam int A  = $clog2(N_REGS);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             alu_valid;
  logic [A-1:0]     alu_addr;
  logic [WIDTH-1:0] alu_data;
  logic             mem_valid;
  logic [A-1:0]     mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic             in_ready;
  logic             RegWrite;
  logic [A-1:0]     write_address;
  logic [WIDTH-1:0] write_data;
  logic [A-1:0]     fwd_addr1;
  logic [A-1:0]     fwd_addr2;
  logic             fwd_hit1;
  logic             fwd_hit2;
  logic [WIDTH-1:0] fwd_data1;
  logic [WIDTH-1:0] fwd_data2;
  logic [CW-1:0]    count;
  logic             overflow;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, fwd_addr1, fwd_addr2,
    input  in_ready, RegWrite, write_address, write_data, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
           count, overflow
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, fwd_addr1, fwd_addr2,
    output in_ready, RegWrite, write_address, write_data, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
           count, overflow
  );
endinterface

// File: rtl/wb_write_queue.sv
// Circular writeback queue: accepts up to two results per cycle (load older than ALU), drains one
// per cycle to the register file, and bypasses the youngest queued value to two decode lookups.
module wb_write_queue #(
  parameter int WIDTH  = 16,
  parameter int N_REGS = 8,
  parameter int DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  wb_write_queue_if.slave bus
);
  localparam int A  = $clog2(N_REGS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("wb_write_queue: DEPTH must be a power of two and at least 2");
  end

  logic [A-1:0]     addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;

  logic          in_ready_c;
  logic          any_valid;
  logic          accept;
  logic          pop;
  logic [CW-1:0] n_push;
  logic [CW-1:0] count_next;
  logic [PW-1:0] tail_p1;

  always_comb begin
    in_ready_c = (CW'(DEPTH) - count_q) >= CW'(2);
    any_valid  = bus.alu_valid || bus.mem_valid;
    accept     = in_ready_c && any_valid;
    pop        = (count_q != '0);
    n_push     = accept ? (CW'(bus.alu_valid) + CW'(bus.mem_valid)) : '0;
    count_next = count_q + n_push - CW'(pop);
    tail_p1    = tail_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) head_q <= head_q + PW'(1);
      tail_q  <= tail_q + PW'(n_push);
      count_q <= count_next;
      if (!in_ready_c && any_valid) overflow_q <= 1'b1;
    end
  end

  // Payload needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (bus.mem_valid) begin
        addr_q[tail_q] <= bus.mem_addr;
        data_q[tail_q] <= bus.mem_data;
        if (bus.alu_valid) begin
          addr_q[tail_p1] <= bus.alu_addr;
          data_q[tail_p1] <= bus.alu_data;
        end
      end else begin
        addr_q[tail_q] <= bus.alu_addr;
        data_q[tail_q] <= bus.alu_data;
      end
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PW-1:0] idx;
    idx           = '0;
    bus.fwd_hit1  = 1'b0;
    bus.fwd_hit2  = 1'b0;
    bus.fwd_data1 = '0;
    bus.fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_q[idx] == bus.fwd_addr1) begin
          bus.fwd_hit1  = 1'b1;
          bus.fwd_data1 = data_q[idx];
        end
        if (addr_q[idx] == bus.fwd_addr2) begin
          bus.fwd_hit2  = 1'b1;
          bus.fwd_data2 = data_q[idx];
        end
      end
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.RegWrite      = pop;
  assign bus.write_address = pop ? addr_q[head_q] : '0;
  assign bus.write_data    = pop ? data_q[head_q] : '0;
  assign bus.count         = count_q;
  assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed scenarios plus random traffic against a queue-based reference.
module tb_wb_write_queue;
  localparam int W = 16;
  localparam int R = 8;
  localparam int D = 4;
  localparam int A = $clog2(R);

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  logic [A+W-1:0] exp_q[$];
  bit             exp_ovf;

  wb_write_queue_if #(.WIDTH(W), .N_REGS(R), .DEPTH(D)) bus ();

  wb_write_queue #(.WIDTH(W), .N_REGS(R), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: a plain list of {addr,data}, oldest first
  task automatic model_edge();
    bit rdy;
    rdy = (D - exp_q.size()) >= 2;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (rdy) begin
      if (bus.mem_valid) exp_q.push_back({bus.mem_addr, bus.mem_data});
      if (bus.alu_valid) exp_q.push_back({bus.alu_addr, bus.alu_data});
    end else if (bus.mem_valid || bus.alu_valid) begin
      exp_ovf = 1'b1;
    end
  endtask

  function automatic void fwd_lookup(input logic [A-1:0] a, output logic hit, output logic [W-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i][A+W-1:W] == a) begin
        hit = 1'b1;
        d   = exp_q[i][W-1:0];
        break;
      end
    end
  endfunction

  task automatic check_outputs();
    logic         h1, h2;
    logic [W-1:0] d1, d2;
    logic [A+W-1:0] hd;
    hd = (exp_q.size() != 0) ? exp_q[0] : '0;
    fwd_lookup(bus.fwd_addr1, h1, d1);
    fwd_lookup(bus.fwd_addr2, h2, d2);
    check("regwrite", bus.RegWrite, exp_q.size() != 0);
    check("write_address", bus.write_address, hd[A+W-1:W]);
    check("write_data", bus.write_data, hd[W-1:0]);
    check("count", bus.count, exp_q.size());
    check("in_ready", bus.in_ready, (D - exp_q.size()) >= 2);
    check("overflow", bus.overflow, exp_ovf);
    check("fwd_hit1", bus.fwd_hit1, h1);
    check("fwd_data1", bus.fwd_data1, d1);
    check("fwd_hit2", bus.fwd_hit2, h2);
    check("fwd_data2", bus.fwd_data2, d2);
  endtask

  // driver: drive at negedge, check pre-edge state, then advance model at posedge
  task automatic cycle(input bit av, input logic [A-1:0] aa, input logic [W-1:0] ad,
                       input bit mv, input logic [A-1:0] ma, input logic [W-1:0] md,
                       input logic [A-1:0] f1, input logic [A-1:0] f2);
    @(negedge clk);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    bus.fwd_addr1 = f1; bus.fwd_addr2 = f2;
    #1 check_outputs();
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    #2 rst = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    check("rst_regwrite", bus.RegWrite, 1'b0);
    check("rst_count", bus.count, 0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_ovf    = 1'b0;
    rst        = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.fwd_addr1 = '0;   bus.fwd_addr2 = '0;
    #1;
    check("reset_regwrite", bus.RegWrite, 1'b0);
    check("reset_write_data", bus.write_data, 0);
    check("reset_count", bus.count, 0);
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_fwd_hit1", bus.fwd_hit1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single push, latency 1
    cycle(1'b1, 3'd3, 16'h1234, 1'b0, '0, '0, '0, '0);
    #1;
    check("single_regwrite", bus.RegWrite, 1'b1);
    check("single_addr", bus.write_address, 3);
    check("single_data", bus.write_data, 16'h1234);
    idle();
    #1;
    check("single_drained", bus.RegWrite, 1'b0);
    check("single_count", bus.count, 0);

    // dual push to the same register: two ordered writes, youngest forwarded
    cycle(1'b1, 3'd2, 16'h5555, 1'b1, 3'd2, 16'hAAAA, 3'd2, 3'd0);
    #1;
    check("dual_count", bus.count, 2);
    check("dual_first", bus.write_data, 16'hAAAA);
    check("dual_fwd_hit", bus.fwd_hit1, 1'b1);
    check("dual_fwd_data", bus.fwd_data1, 16'h5555);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 3'd2, 3'd0);
    #1;
    check("dual_second", bus.write_data, 16'h5555);
    check("dual_second_addr", bus.write_address, 2);
    check("dual_fwd_after_pop", bus.fwd_data1, 16'h5555);
    idle();

    // fill until in_ready drops, then a dropped push sets overflow
    cycle(1'b1, 3'd1, 16'h0011, 1'b1, 3'd5, 16'h0022, '0, '0);
    #1 check("fill_count_2", bus.count, 2);
    cycle(1'b1, 3'd6, 16'h0033, 1'b1, 3'd7, 16'h0044, '0, '0);
    #1 check("fill_count_3", bus.count, 3);
    check("fill_not_ready", bus.in_ready, 1'b0);
    cycle(1'b1, 3'd0, 16'h0055, 1'b1, 3'd0, 16'h0066, 3'd0, '0);
    #1 check("fill_overflow", bus.overflow, 1'b1);
    check("fill_dropped", bus.count, 2);
    check("fill_no_fwd", bus.fwd_hit1, 1'b0);
    repeat (3) idle();

    // forward miss with r1, r4 queued
    cycle(1'b1, 3'd4, 16'h4444, 1'b1, 3'd1, 16'h1111, '0, '0);
    bus.fwd_addr1 = 3'd4;
    bus.fwd_addr2 = 3'd6;
    #1;
    check("miss_hit2", bus.fwd_hit2, 1'b0);
    check("miss_data2", bus.fwd_data2, 0);
    check("hit_r4", bus.fwd_data1, 16'h4444);
    repeat (2) idle();

    // reset mid-operation at count 3
    cycle(1'b1, 3'd1, 16'h0101, 1'b1, 3'd2, 16'h0202, '0, '0);
    cycle(1'b1, 3'd3, 16'h0303, 1'b1, 3'd4, 16'h0404, '0, '0);
    #1 check("pre_reset_count", bus.count, 3);
    async_reset();
    repeat (3) idle();

    // random traffic, with one reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) async_reset();
      cycle(($urandom_range(0, 99) < 45), A'($urandom_range(0, R - 1)), W'($urandom),
            ($urandom_range(0, 99) < 45), A'($urandom_range(0, R - 1)), W'($urandom),
            A'($urandom_range(0, R - 1)), A'($urandom_range(0, R - 1)));
    end
    repeat (4) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
